// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// Elastic pipeline register with a valid/ready handshake on both sides.
// It is placed between pipeline stages where the downstream stage can stall,
// for example fetch->decode or execute->memory.
//
// The block holds one main entry and one skid entry. The main entry drives
// the output. The skid entry catches the word that upstream sends in the
// same cycle that downstream stalls. Because of this, in_ready can come
// straight from a flop and still keep full throughput. A synchronous flush
// squashes every held entry, for branch and exception recovery.
//
// Optional feature macro: PIPE_SKID_STATS_EN
//   When it is defined, the block gets the parameter CNT_WIDTH and the output
//   stall_cnt. stall_cnt is a saturating count of cycles with out_valid=1 and
//   out_ready=0. Only reset clears it. The datapath is the same in both builds.
//
// Parameters
//   WIDTH      payload width in bits
//   CNT_WIDTH  stall-counter width (only with PIPE_SKID_STATS_EN)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   flush      in   synchronous squash of all held entries
//   in_valid   in   upstream offers in_data
//   in_data    in   upstream payload [WIDTH-1:0]
//   in_ready   out  register can accept; driven from a flop only
//   out_valid  out  main entry valid
//   out_data   out  main entry payload [WIDTH-1:0]
//   out_ready  in   downstream accepts out_data
//   stall_cnt  out  saturating stall count [CNT_WIDTH-1:0] (stats build only)
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int WIDTH = 32
`ifdef PIPE_SKID_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_SKID_STATS_EN
  , output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  // The state encoding is {skid_v, main_v}. Encoding 2'b10 can never occur,
  // because the skid entry only fills when the main entry is already valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_main_q;
  logic [WIDTH-1:0]   r_skid_q;
  logic               r_in_ready;

  logic               w_main_v;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;

  assign w_main_v   = r_state[0];
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = w_main_v & out_ready;

  // Next-state and load-enable decode. Flush has priority over all traffic.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      // A word offered in this cycle is dropped, even when in_ready=1.
      // The data registers keep their contents; they are don't-care once
      // their valid bits are cleared.
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt    = ST_ONE;
            w_load_main_in = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_state_nxt    = ST_ONE;
            w_load_main_in = 1'b1;
          end else if (w_in_xfer) begin
            // Downstream stalled while upstream sent a word: park it in skid.
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no input transfer can happen.
          if (w_out_xfer) begin
            w_state_nxt      = ST_ONE;
            w_load_main_skid = 1'b1;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // State register, which also holds the valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // in_ready comes from its own flop, so out_ready has no combinational path to it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // Main payload register. It loads only on an accepted word, so an X on
  // in_data while in_valid=0 never gets in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_q <= {WIDTH{1'b0}};
    end else if (w_load_main_in) begin
      r_main_q <= in_data;
    end else if (w_load_main_skid) begin
      r_main_q <= r_skid_q;
    end else begin
      r_main_q <= r_main_q;
    end
  end

  // Skid payload register. It holds the word that arrives during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_q <= {WIDTH{1'b0}};
    end else if (w_load_skid) begin
      r_skid_q <= in_data;
    end else begin
      r_skid_q <= r_skid_q;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_v;
  assign out_data  = r_main_q;

`ifdef PIPE_SKID_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic                 w_stall;

  assign w_stall = w_main_v & ~out_ready;

  // Saturating stall counter. Flush does not clear it; only reset does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= {CNT_WIDTH{1'b0}};
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
